br_write_arbiter: RTL and testbench

Owns the single write port of the 32x32 register file and shares it between two writeback requesters: port A (ALU result) and port B (load data).
After reset it runs a clear sweep that writes zero to every register, then arbitrates round-robin with valid/ready handshakes.
Outputs are registered and drive the register file's we/WA/DW inputs directly.
Writes to register 0 are optionally discarded, giving a hardwired-zero r0.

---
 rtl/br_write_arbiter.sv | 118 +++++++++++
 tb/tb_br_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/br_write_arbiter.sv
// Register-file write-port owner: post-reset clear sweep, then round-robin
// arbitration between writeback port A (ALU) and port B (load data).
module br_write_arbiter #(
  parameter int unsigned AW             = 5,
  parameter int unsigned DWID           = 32,
  parameter int unsigned NREG           = 32,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned ZERO_REG       = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [DWID-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [DWID-1:0] b_data,
  output logic            b_ready,
  output logic            br_we,
  output logic [AW-1:0]   br_wa,
  output logic [DWID-1:0] br_dw,
  output logic            init_done
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   cnt;
  logic            last_b;
  logic            grant_a;
  logic            grant_b;
  logic            we_next;
  logic [AW-1:0]   wa_next;
  logic [DWID-1:0] dw_next;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: sweep ends after the write to the last register is issued
  always_comb begin
    state_next = state;
    if (state == S_CLEAR && cnt == LAST_ADDR) begin
      state_next = S_RUN;
    end
  end

  // Grant, handshake and next write-port values
  always_comb begin
    grant_a = a_valid & (~b_valid | last_b);
    grant_b = b_valid & (~a_valid | ~last_b);
    a_ready = rst_n & (state == S_RUN) & grant_a;
    b_ready = rst_n & (state == S_RUN) & grant_b;
    we_next = 1'b0;
    wa_next = br_wa;
    dw_next = br_dw;
    case (state)
      S_CLEAR: begin
        we_next = 1'b1;
        wa_next = cnt;
        dw_next = '0;
      end
      S_RUN: begin
        // A write to r0 still handshakes but is suppressed at the port
        if (a_ready) begin
          we_next = !((ZERO_REG != 0) && (a_addr == '0));
          wa_next = a_addr;
          dw_next = a_data;
        end else if (b_ready) begin
          we_next = !((ZERO_REG != 0) && (b_addr == '0));
          wa_next = b_addr;
          dw_next = b_data;
        end
      end
      default: begin
        we_next = 1'b0;
      end
    endcase
  end

  // Registered write port, sweep counter and round-robin history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_we     <= 1'b0;
      br_wa     <= '0;
      br_dw     <= '0;
      init_done <= 1'b0;
      cnt       <= '0;
      last_b    <= 1'b1;
    end else begin
      br_we     <= we_next;
      br_wa     <= wa_next;
      br_dw     <= dw_next;
      init_done <= (state == S_RUN);
      if (state == S_CLEAR) begin
        cnt <= cnt + AW'(1);
      end
      if (a_ready) begin
        last_b <= 1'b0;
      end else if (b_ready) begin
        last_b <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_br_write_arbiter.sv
// Randomized and directed bench for br_write_arbiter against a cycle-level
// behavioural model of the sweep/round-robin rules.
module tb_br_write_arbiter;

  localparam int unsigned AW   = 5;
  localparam int unsigned DWID = 32;
  localparam int unsigned NREG = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_valid;
  logic [AW-1:0]   a_addr;
  logic [DWID-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [AW-1:0]   b_addr;
  logic [DWID-1:0] b_data;
  logic            b_ready;
  logic            br_we;
  logic [AW-1:0]   br_wa;
  logic [DWID-1:0] br_dw;
  logic            init_done;

  br_write_arbiter #(
    .AW(AW), .DWID(DWID), .NREG(NREG), .CLEAR_ON_RESET(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .br_we(br_we), .br_wa(br_wa), .br_dw(br_dw), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: sweep progress, who was served last, expected registered outputs
  bit          m_clearing;
  int          m_sweep;
  bit          m_last_b;
  bit          m_known;
  bit          e_we;
  int unsigned e_wa;
  int unsigned e_dw;
  bit          e_init;
  bit          ea;
  bit          eb;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // One clock: compare everything before the edge, then advance the model on the edge
  task automatic cycle();
    #1;
    ea = rst_n && !m_clearing && a_valid && (!b_valid || m_last_b);
    eb = rst_n && !m_clearing && b_valid && (!a_valid || !m_last_b);
    if (m_known) begin
      chk("a_ready", 32'(a_ready), 32'(ea));
      chk("b_ready", 32'(b_ready), 32'(eb));
      chk("br_we", 32'(br_we), 32'(e_we));
      chk("init_done", 32'(init_done), 32'(e_init));
      if (e_we) begin
        chk("br_wa", 32'(br_wa), e_wa);
        chk("br_dw", br_dw, e_dw);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known    = 1'b1;
      m_clearing = 1'b1;
      m_sweep    = 0;
      m_last_b   = 1'b1;
      e_we = 0; e_wa = 0; e_dw = 0; e_init = 0;
    end else begin
      e_init = !m_clearing;
      if (m_clearing) begin
        e_we = 1; e_wa = m_sweep; e_dw = 0;
        m_sweep++;
        if (m_sweep == NREG) m_clearing = 1'b0;
      end else if (ea) begin
        m_last_b = 1'b0;
        e_we = (a_addr != 0); e_wa = a_addr; e_dw = a_data;
      end else if (eb) begin
        m_last_b = 1'b1;
        e_we = (b_addr != 0); e_wa = b_addr; e_dw = b_data;
      end else begin
        e_we = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0;
  endtask

  // Sweep after reset release: literal checks of every clear write
  task automatic sweep_check();
    for (int i = 0; i < int'(NREG); i++) begin
      cycle();
      chk("sweep_we", 32'(br_we), 32'd1);
      chk("sweep_wa", 32'(br_wa), 32'(i));
      chk("sweep_dw", br_dw, 32'd0);
      chk("sweep_rdy", 32'({a_ready, b_ready}), 32'd0);
    end
  endtask

  bit          pa, pb;
  logic [AW-1:0]   ra, rb;
  logic [DWID-1:0] da, db;

  initial begin
    m_known = 1'b0;
    m_clearing = 1'b1; m_sweep = 0; m_last_b = 1'b1;
    e_we = 0; e_wa = 0; e_dw = 0; e_init = 0;
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("rst_we", 32'(br_we), 32'd0);
    chk("rst_wa", 32'(br_wa), 32'd0);
    chk("rst_dw", br_dw, 32'd0);
    chk("rst_init", 32'(init_done), 32'd0);

    // Full sweep, then init_done one cycle after the last clear write
    rst_n = 1;
    sweep_check();
    chk("init_late", 32'(init_done), 32'd0);
    cycle();
    chk("init_up", 32'(init_done), 32'd1);
    chk("post_we", 32'(br_we), 32'd0);

    // Single A write
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    cycle();
    chk("single_ardy", 32'(ea), 32'd1);
    a_valid = 0;
    chk("single_we", 32'(br_we), 32'd1);
    chk("single_wa", 32'(br_wa), 32'd5);
    chk("single_dw", br_dw, 32'hDEADBEEF);
    cycle();
    chk("single_we0", 32'(br_we), 32'd0);

    // Write to r0 from B: handshake but no write enable
    b_valid = 1; b_addr = 0; b_data = 32'h55;
    cycle();
    chk("r0_brdy", 32'(b_ready === 1'b1 || eb), 32'd1);
    b_valid = 0;
    chk("r0_we", 32'(br_we), 32'd0);

    // Tie held for 4 cycles: A,B,A,B
    a_valid = 1; a_addr = 3; a_data = 32'h11;
    b_valid = 1; b_addr = 4; b_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("tie_grant_a", 32'(ea), 32'((k % 2) == 0));
      chk("tie_wa", 32'(br_wa), (k % 2) == 0 ? 32'd3 : 32'd4);
      chk("tie_we", 32'(br_we), 32'd1);
    end
    idle_inputs();
    cycle();
    chk("tie_end_we", 32'(br_we), 32'd0);

    // Reset mid-sweep at address 17, then a full restart
    rst_n = 0; cycle();
    rst_n = 1;
    for (int i = 0; i < 18; i++) cycle();
    chk("mid_wa17", 32'(br_wa), 32'd17);
    rst_n = 0; cycle();
    chk("mid_rst_we", 32'(br_we), 32'd0);
    rst_n = 1;
    sweep_check();
    cycle();
    chk("mid_init", 32'(init_done), 32'd1);

    // Reset while an A request is pending
    a_valid = 1; a_addr = 9; a_data = 32'h99;
    rst_n = 0; cycle();
    chk("pend_rst_we", 32'(br_we), 32'd0);
    rst_n = 1;
    for (int i = 0; i < int'(NREG); i++) cycle();
    cycle();
    chk("pend_we", 32'(br_we), 32'd1);
    chk("pend_wa", 32'(br_wa), 32'd9);
    chk("pend_dw", br_dw, 32'h99);
    a_valid = 0;
    cycle();

    // Randomized traffic with occasional resets
    pa = 0; pb = 0; ra = '0; rb = '0; da = '0; db = '0;
    for (int n = 0; n < 4000; n++) begin
      if (ea) pa = 0;
      if (eb) pb = 0;
      if (!pa && $urandom_range(0, 2) == 0) begin
        pa = 1;
        ra = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 31));
        da = $urandom;
      end
      if (!pb && $urandom_range(0, 2) == 0) begin
        pb = 1;
        rb = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 31));
        db = $urandom;
      end
      a_valid = pa; a_addr = ra; a_data = da;
      b_valid = pb; b_addr = rb; b_data = db;
      rst_n = ($urandom_range(0, 599) != 0);
      ea = 0; eb = 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
